// File: rtl/textlcd_pkg.sv
// Shared constants and helpers for the text-LCD responder: opcode masks,
// DDRAM line bounds, address-counter stepping and DDRAM linear indexing.
package textlcd_pkg;

  localparam logic [7:0] MASK_DDRAM   = 8'h80;
  localparam logic [7:0] MASK_CGRAM   = 8'h40;
  localparam logic [7:0] MASK_FUNC    = 8'h20;
  localparam logic [7:0] MASK_SHIFT   = 8'h10;
  localparam logic [7:0] MASK_DISPLAY = 8'h08;
  localparam logic [7:0] MASK_ENTRY   = 8'h04;
  localparam logic [7:0] MASK_HOME    = 8'h02;
  localparam logic [7:0] MASK_CLEAR   = 8'h01;

  localparam logic [6:0] LINE0_BASE  = 7'h00;
  localparam logic [6:0] LINE0_LIMIT = 7'h27;
  localparam logic [6:0] LINE1_BASE  = 7'h40;
  localparam logic [6:0] LINE1_LIMIT = 7'h67;

  localparam logic [7:0] SPACE = 8'h20;

  localparam int unsigned DDRAM_DEPTH   = 80;
  localparam logic [6:0]  DDRAM_DEPTH_W = 7'd80;

  typedef enum logic [3:0] {
    INS_NOP, INS_CLEAR, INS_HOME, INS_ENTRY, INS_DISPLAY,
    INS_SHIFT, INS_FUNC, INS_CGRAM, INS_DDRAM
  } instr_t;

  // The highest set bit selects the instruction.
  function automatic instr_t decode_instr(input logic [7:0] b);
    if ((b & MASK_DDRAM)   != '0) return INS_DDRAM;
    if ((b & MASK_CGRAM)   != '0) return INS_CGRAM;
    if ((b & MASK_FUNC)    != '0) return INS_FUNC;
    if ((b & MASK_SHIFT)   != '0) return INS_SHIFT;
    if ((b & MASK_DISPLAY) != '0) return INS_DISPLAY;
    if ((b & MASK_ENTRY)   != '0) return INS_ENTRY;
    if ((b & MASK_HOME)    != '0) return INS_HOME;
    if ((b & MASK_CLEAR)   != '0) return INS_CLEAR;
    return INS_NOP;
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= LINE0_LIMIT) || (a >= LINE1_BASE && a <= LINE1_LIMIT);
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == LINE0_LIMIT) return LINE1_BASE;
      if (a == LINE1_LIMIT) return LINE0_BASE;
      return a + 7'd1;
    end
    if (a == LINE0_BASE) return LINE1_LIMIT;
    if (a == LINE1_BASE) return LINE0_LIMIT;
    return a - 7'd1;
  endfunction

  function automatic logic [6:0] ddram_index(input logic [6:0] a);
    return {1'b0, a[5:0]} + (a[6] ? 7'd40 : 7'd0);
  endfunction

endpackage

// File: rtl/textlcd_ddram.sv
// 80x8 DDRAM image: one write port, combinational bus read port A and a
// registered host read port B. Addresses are LCD addresses (two 40-byte lines).
module textlcd_ddram
  import textlcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [6:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [7:0] mem [DDRAM_DEPTH];
  logic [6:0] widx, aidx, bidx;

  always_comb begin
    widx = ddram_index(waddr);
    aidx = ddram_index(raddr_a);
    bidx = ddram_index(raddr_b);
  end

  assign rdata_a = (aidx < DDRAM_DEPTH_W) ? mem[aidx] : SPACE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DDRAM_DEPTH; i++) mem[7'(i)] <= SPACE;
      rdata_b <= '0;
    end else begin
      if (we && widx < DDRAM_DEPTH_W) mem[widx] <= wdata;
      rdata_b <= (bidx < DDRAM_DEPTH_W) ? mem[bidx] : SPACE;
    end
  end

endmodule

// File: rtl/textlcd_receiver.sv
// Display-side HD44780-style responder: synchronises the 8-bit LCD bus,
// commits transfers on the en falling edge and executes them against DDRAM.
module textlcd_receiver
  import textlcd_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES  = 40,
  parameter int unsigned CLEAR_CYCLES = 1600
) (
  input  logic       lcdclk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data_i,
  output logic [7:0] lcd_data_o,
  output logic       lcd_data_oe,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       ev_valid,
  output logic       ev_rs,
  output logic [7:0] ev_byte,
  output logic       busy,
  output logic       disp_on,
  output logic       err_busy,
  output logic       err_addr
);

  localparam int unsigned CW = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXEC, CLEARING, BUSY} state_t;

  state_t     state;
  logic [1:0] rs_sy, rw_sy, en_sy;
  logic [7:0] d_s1, d_s2, d_q;
  logic       rs_q, rw_q, en_q, seen_low;
  logic [6:0] ac, sweep_addr, ram_waddr;
  logic       id;
  logic [CW-1:0] cnt;
  logic [7:0] ram_wdata, ram_a;
  logic       fall, wr_fall, wr_commit, long_busy, bus_we, sweep_we, clr_commit;
  instr_t     ins;

  // en syncs reset high and seen_low must see it low first, so a pulse
  // already in progress when reset releases never commits.
  always_ff @(posedge lcdclk or posedge reset) begin
    if (reset) begin
      rs_sy <= '0; rw_sy <= '0; en_sy <= '1;
      d_s1 <= '0; d_s2 <= '0; d_q <= '0;
      rs_q <= 1'b0; rw_q <= 1'b0; en_q <= 1'b1; seen_low <= 1'b0;
    end else begin
      rs_sy <= {rs_sy[0], lcd_rs};
      rw_sy <= {rw_sy[0], lcd_rw};
      en_sy <= {en_sy[0], lcd_en};
      d_s1 <= lcd_data_i;
      d_s2 <= d_s1;
      rs_q <= rs_sy[1]; rw_q <= rw_sy[1]; en_q <= en_sy[1]; d_q <= d_s2;
      seen_low <= seen_low | ~en_q;
    end
  end

  always_comb begin
    fall       = seen_low & en_q & ~en_sy[1];
    ins        = decode_instr(d_q);
    wr_fall    = fall & ~rw_q;
    wr_commit  = wr_fall & (rs_q | (ins != INS_NOP));
    long_busy  = ~rs_q & ((ins == INS_CLEAR) | (ins == INS_HOME));
    clr_commit = wr_fall & ~rs_q & (ins == INS_CLEAR);
    bus_we     = wr_fall & rs_q;
    sweep_we   = (state == CLEARING) & ~bus_we;
    ram_waddr  = bus_we ? ac : sweep_addr;
    ram_wdata  = bus_we ? d_q : SPACE;
  end

  textlcd_ddram u_ddram (
    .clk     (lcdclk),
    .rst     (reset),
    .we      (bus_we | sweep_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (ac),
    .rdata_a (ram_a),
    .raddr_b (rd_addr),
    .rdata_b (rd_data)
  );

  always_ff @(posedge lcdclk or posedge reset) begin
    if (reset) begin
      state <= IDLE; ac <= '0; id <= 1'b1; cnt <= '0; sweep_addr <= LINE0_BASE;
      lcd_data_o <= '0; lcd_data_oe <= 1'b0;
      ev_valid <= 1'b0; ev_rs <= 1'b0; ev_byte <= '0;
      busy <= 1'b0; disp_on <= 1'b0; err_busy <= 1'b0; err_addr <= 1'b0;
    end else begin
      ev_valid <= wr_fall;
      if (wr_fall) begin
        ev_rs   <= rs_q;
        ev_byte <= d_q;
        if (busy) err_busy <= 1'b1;
      end

      lcd_data_oe <= rw_sy[1] & en_sy[1];
      lcd_data_o  <= (rw_sy[1] & en_sy[1]) ? (rs_sy[1] ? ram_a : {busy, ac}) : '0;

      if (wr_commit) begin
        busy <= 1'b1;
        cnt  <= long_busy ? CW'(CLEAR_CYCLES - 1) : CW'(BUSY_CYCLES - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        busy <= 1'b0;
      end

      if (fall & rs_q) begin
        ac <= ac_step(ac, id);
      end else if (wr_fall) begin
        case (ins)
          INS_DDRAM:   if (addr_valid(d_q[6:0])) ac <= d_q[6:0]; else err_addr <= 1'b1;
          INS_DISPLAY: disp_on <= d_q[2];
          INS_ENTRY:   id <= d_q[1];
          INS_HOME:    ac <= '0;
          INS_CLEAR:   begin ac <= '0; id <= 1'b1; end
          default:     ;
        endcase
      end

      if (sweep_we) sweep_addr <= ac_step(sweep_addr, 1'b1);

      // Bus writes steal the write port; the sweep pauses for that cycle.
      if (clr_commit) begin
        state      <= CLEARING;
        sweep_addr <= LINE0_BASE;
      end else if (state == CLEARING) begin
        if (sweep_we && sweep_addr == LINE1_LIMIT) state <= BUSY;
      end else if (fall) begin
        state <= EXEC;
      end else begin
        state <= busy ? BUSY : IDLE;
      end
    end
  end

endmodule
